l1_dcache: RTL and testbench
============================

// Module: l1_dcache
// PURPOSE
// Data-side responder for the RV32I core's data memory port: the core presents address
// (ALUResult), store data, MemWrite, load-enable and store format. It answers with read data
// and a stall.
// Direct-mapped, write-through, no-write-allocate cache with 4-word lines. It sits between
// the core and a word-wide backing memory with a req/ack handshake. Read hits answer
// combinationally in the same cycle. Misses and all stores stall the core until the backing
// memory completes.
// PARAMETERS
// LINES   16   number of cache lines (power of 2, >=2); tag = addr[31:4+log2(LINES)]
// PORTS
// clk        in   1   clock, all state on rising edge
// rst        in   1   reset, asynchronous, active-high
// addr       in   32  byte address from core (ALUResult)
// wdata      in   32  store data, payload in low bits (byte [7:0], half [15:0], word [31:0])
// we         in   1   store request (MemWrite)
// re         in   1   load request
// wfrmt      in   2   store size: 00 byte, 01 half, 10 word (11 treated as word)
// rdata      out  32  load data: addressed word >> (8*addr[1:0]), zero-filled; core extends
// stall      out  1   core must hold PC and all inputs while high
// misalign   out  1   access not naturally aligned; access suppressed
// mem_req    out  1   backing memory request, held until ack
// mem_we     out  1   1 = write beat, 0 = read beat
// mem_addr   out  32  word-aligned backing address (addr[1:0]=00)
// mem_wdata  out  32  write data, lane-shifted
// mem_wstrb  out  4   byte strobes for write beats, 0000 on reads
// mem_ack    in   1   beat complete this cycle; mem_rdata valid on read beats
// mem_rdata  in   32  read beat data
// BEHAVIOUR
// - Reset (async) values:
//   - state IDLE; all valid bits 0; beat counter 0.
//   - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
//   - stall=0, misalign=0, rdata=0.
// - Reset mid-operation abandons the transaction: mem_req drops immediately. The backing
//   memory must tolerate a dropped request.
// - Misalign (combinational):
//   - Flagged when (re|we) and either: half with addr[0]=1, or word with addr[1:0]!=0.
//   - Load size taken from wfrmt.
//   - Misaligned access: misalign=1, stall=0, rdata=0, no cache update, no mem_req.
// - Both we and re high: treated as a store.
// - Strobes (word-aligned store):
//   - mem_wstrb = 0001/0011/1111 (byte/half/word) << addr[1:0].
//   - mem_wdata = wdata << 8*addr[1:0].
// - FSM IDLE / REFILL / WRITE / DONE:
//   - IDLE, load hit: stall=0, rdata from array same cycle, stay IDLE.
//   - IDLE, load miss: stall=1, go REFILL with beat=0.
//   - IDLE, store: stall=1, go WRITE.
//   - IDLE, no request: stall=0.
//   - REFILL: mem_req=1, mem_we=0, mem_addr = {addr[31:4], beat, 2'b00}.
//     - Each mem_ack: write mem_rdata into word[beat], beat++.
//     - mem_req stays high between beats; the address advances the cycle after the ack.
//     - Ack on beat 3: set valid, write tag, go DONE.
//   - WRITE: mem_req=1, mem_we=1, strobes/data as above.
//     - On mem_ack: if the line is a hit, merge the strobed bytes into the cached word in
//       that cycle; go DONE.
//     - A miss is not allocated.
//   - DONE: stall=0 for exactly one cycle, then IDLE.
//     - A load hits and returns rdata.
//     - A store still presented is ignored (not re-issued).
// - stall is combinational: high in REFILL/WRITE, and in IDLE on load miss or store.
// - Latency with zero-wait ack:
//   - Load miss: stall high 5 cycles, data on 6th.
//   - Store: stall high 2 cycles.
// - A line is never partially valid: valid is set only after all 4 beats.
// TESTING
// - rst, load 0x100; mem acks every cycle with 0x11,0x22,0x33,0x44 at 0x100..0x10C
//   -> stall high 5 cycles, then rdata=0x00000011, stall=0.
// - Then load 0x10C -> same-cycle hit: rdata=0x00000044, stall=0, mem_req stays 0.
// - Store byte 0xAB at 0x101 -> mem_wstrb=0010, mem_wdata=0x0000AB00, mem_addr=0x100.
//   - Then load word 0x100 -> 0x0000AB11.
//   - Load byte 0x101 -> 0x000000AB.
// - Load 0x200 (same index, LINES=16) refills and evicts -> load 0x100 then misses (mem_req=1).
// - Word load at 0x102 -> misalign=1, stall=0, mem_req never asserts, no valid change.
// - rst pulse during refill beat 2 -> mem_req=0 that cycle, stall=0.
//   - Next load 0x100 misses and refills all 4 beats.

Source files
------------

// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped, write-through, no-write-allocate data cache with
// 4-word lines, sitting between the RV32I core data port and a word-wide
// backing memory with a req/ack handshake. Read hits answer in the same cycle;
// misses and every store stall the core until the backing memory completes.
module l1_dcache #(
  parameter int unsigned LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic [1:0]  wfrmt,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 28 - IW;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [LINES-1:0]  valid_q;
  logic [TW-1:0]     tag_q  [LINES];
  logic [31:0]       data_q [LINES][4];

  logic [IW-1:0]     idx;
  logic [TW-1:0]     tag;
  logic              hit;
  logic [31:0]       word_rd;
  logic [31:0]       rd_shifted;
  logic [3:0]        strb_base;
  logic [3:0]        wr_strb;
  logic [31:0]       wr_data;
  logic              misal_c;
  logic              is_store;
  logic              is_load;
  logic              refill_wr;
  logic              refill_last;
  logic              store_merge;

  assign idx        = addr[4 +: IW];
  assign tag        = addr[31 -: TW];
  assign hit        = valid_q[idx] && (tag_q[idx] == tag);
  assign word_rd    = data_q[idx][addr[3:2]];
  assign rd_shifted = word_rd >> {addr[1:0], 3'b000};
  assign wr_strb    = strb_base << addr[1:0];
  assign wr_data    = wdata << {addr[1:0], 3'b000};

  // Access size decode, natural-alignment check and request classification
  always_comb begin
    strb_base = 4'b1111;
    misal_c   = 1'b0;
    case (wfrmt)
      2'b00:   strb_base = 4'b0001;
      2'b01:   strb_base = 4'b0011;
      default: strb_base = 4'b1111;
    endcase
    if (re || we) begin
      if (wfrmt == 2'b01)
        misal_c = addr[0];
      else if (wfrmt[1])
        misal_c = (addr[1:0] != 2'b00);
    end
    is_store = we && !misal_c;
    is_load  = re && !we && !misal_c;
  end

  // Next-state logic and all core/backing-memory outputs
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    rdata       = '0;
    stall       = 1'b0;
    misalign    = misal_c;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    refill_wr   = 1'b0;
    refill_last = 1'b0;
    store_merge = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_store) begin
          stall   = 1'b1;
          state_d = WRITE;
        end else if (is_load) begin
          if (hit) begin
            rdata = rd_shifted;
          end else begin
            stall   = 1'b1;
            beat_d  = '0;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {addr[31:4], beat_q, 2'b00};
        if (mem_ack) begin
          refill_wr = 1'b1;
          beat_d    = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            refill_last = 1'b1;
            state_d     = DONE;
          end
        end
      end
      WRITE: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr[31:2], 2'b00};
        mem_wdata = wr_data;
        mem_wstrb = wr_strb;
        if (mem_ack) begin
          store_merge = hit;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (is_load && hit)
          rdata = rd_shifted;
      end
      default: state_d = IDLE;
    endcase
    // Reset forces the IDLE state asynchronously; these keep a held request
    // from raising stall/misalign/rdata while reset is still asserted.
    if (rst) begin
      stall    = 1'b0;
      misalign = 1'b0;
      rdata    = '0;
    end
  end

  // State, beat counter and valid bits with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (refill_last)
        valid_q[idx] <= 1'b1;
    end
  end

  // Line data and tags: refill beats and write-through merge on store hits
  always_ff @(posedge clk) begin
    if (refill_wr)
      data_q[idx][beat_q] <= mem_rdata;
    if (refill_last)
      tag_q[idx] <= tag;
    if (store_merge) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_strb[b])
          data_q[idx][addr[3:2]][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_l1_dcache.sv
// Scoreboard bench for l1_dcache: the driver pushes expected memory beats and
// load results into queues; a negedge monitor pops and compares them whenever
// the DUT presents a memory beat or completes a load.
module tb_l1_dcache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [1:0]  wfrmt = 2'b10;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  l1_dcache #(.LINES(16)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .wfrmt(wfrmt), .rdata(rdata), .stall(stall), .misalign(misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Zero-wait backing memory, word-indexed by mem_addr[9:2]
  logic [31:0] mem [256];
  logic        mem_init = 1'b0;
  assign mem_ack   = mem_req;
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | i;
      mem[8'h40] <= 32'h0000_0011; mem[8'h41] <= 32'h0000_0022;
      mem[8'h42] <= 32'h0000_0033; mem[8'h43] <= 32'h0000_0044;
      mem[8'h80] <= 32'h0000_0055; mem[8'h81] <= 32'h0000_0066;
      mem[8'h82] <= 32'h0000_0077; mem[8'h83] <= 32'h0000_0088;
      mem_init <= 1'b1;
    end else if (!rst && mem_req && mem_ack && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } beat_t;

  beat_t       beat_q[$];
  logic [31:0] load_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compare every backing-memory beat and every completed load
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && mem_ack) begin
        if (beat_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got beat at %h we=%b expected none", mem_addr, mem_we);
        end else begin
          beat_t e;
          e = beat_q.pop_front();
          chk("beat_addr", mem_addr, e.addr);
          chk("beat_we", {31'b0, mem_we}, {31'b0, e.we});
          chk("beat_strb", {28'b0, mem_wstrb}, {28'b0, e.strb});
          if (e.we) chk("beat_wdata", mem_wdata, e.wdata);
        end
      end
      if (re && !we && !stall && !misalign) begin
        if (load_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_load: got rdata %h expected no load", rdata);
        end else begin
          chk("load_rdata", rdata, load_q.pop_front());
        end
      end
    end
  end

  task automatic push_refill(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.we = 1'b0; b.addr = base + 32'(4 * i); b.strb = 4'b0000; b.wdata = '0;
      beat_q.push_back(b);
    end
  endtask

  task automatic push_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    beat_t b;
    b.we = 1'b1; b.addr = a; b.strb = s; b.wdata = d;
    beat_q.push_back(b);
  endtask

  // Present a request and count stalled cycles until the DUT releases the core
  task automatic access(input string name, input logic w, input logic [31:0] a,
                        input logic [1:0] f, input logic [31:0] d, input int exp_stalls);
    int cnt = 0;
    @(posedge clk); #1;
    addr = a; wfrmt = f; wdata = d; we = w; re = !w;
    forever begin
      @(negedge clk);
      if (!stall) break;
      cnt++;
      if (cnt > 50) begin
        $display("FAIL %s_timeout: got stall still high after %0d cycles expected release", name, cnt);
        break;
      end
    end
    chk({name, "_stalls"}, 32'(cnt), 32'(exp_stalls));
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic load(input string name, input logic [31:0] a, input logic [1:0] f,
                      input logic [31:0] exp, input int exp_stalls);
    load_q.push_back(exp);
    access(name, 1'b0, a, f, '0, exp_stalls);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Cold miss, then same-line hit
    push_refill(32'h100, 4);
    load("miss_100", 32'h100, 2'b10, 32'h0000_0011, 5);
    load("hit_10c", 32'h10C, 2'b10, 32'h0000_0044, 0);

    // Byte store on a hit, then read back through the cache
    push_write(32'h100, 4'b0010, 32'h0000_AB00);
    access("st_b_101", 1'b1, 32'h101, 2'b00, 32'h0000_00AB, 2);
    load("hit_w_100", 32'h100, 2'b10, 32'h0000_AB11, 0);
    load("hit_b_101", 32'h101, 2'b00, 32'h0000_00AB, 0);

    // Conflict eviction: 0x200 shares the index with 0x100
    push_refill(32'h200, 4);
    load("miss_200", 32'h200, 2'b10, 32'h0000_0055, 5);
    push_refill(32'h100, 4);
    load("remiss_100", 32'h100, 2'b10, 32'h0000_AB11, 5);

    // Half store into upper lanes, merged into the cached word
    push_write(32'h104, 4'b1100, 32'hBEEF_0000);
    access("st_h_106", 1'b1, 32'h106, 2'b01, 32'h0000_BEEF, 2);
    load("hit_w_104", 32'h104, 2'b10, 32'hBEEF_0022, 0);

    // Misaligned word load and misaligned half store are suppressed
    @(posedge clk); #1;
    addr = 32'h102; wfrmt = 2'b10; re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mis_ld_flag", {31'b0, misalign}, 32'h1);
      chk("mis_ld_stall", {31'b0, stall}, 32'h0);
      chk("mis_ld_rdata", rdata, 32'h0);
      chk("mis_ld_req", {31'b0, mem_req}, 32'h0);
    end
    @(posedge clk); #1;
    re = 1'b0; addr = 32'h101; wfrmt = 2'b01; wdata = 32'h1234; we = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mis_st_flag", {31'b0, misalign}, 32'h1);
      chk("mis_st_stall", {31'b0, stall}, 32'h0);
      chk("mis_st_req", {31'b0, mem_req}, 32'h0);
    end
    @(posedge clk); #1 we = 1'b0;
    load("post_mis_100", 32'h100, 2'b10, 32'h0000_AB11, 0);

    // Store miss is written through but not allocated
    push_write(32'h300, 4'b1111, 32'hDEAD_BEEF);
    access("st_w_300", 1'b1, 32'h300, 2'b10, 32'hDEAD_BEEF, 2);
    load("noalloc_100", 32'h100, 2'b10, 32'h0000_AB11, 0);
    push_refill(32'h300, 4);
    load("miss_300", 32'h300, 2'b10, 32'hDEAD_BEEF, 5);

    // Reset during refill beat 2 abandons the transaction
    push_refill(32'h100, 3);
    @(posedge clk); #1;
    addr = 32'h100; wfrmt = 2'b10; re = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("midrst_stall", {31'b0, stall}, 32'h0);
    re = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    push_refill(32'h100, 4);
    load("after_rst_100", 32'h100, 2'b10, 32'h0000_AB11, 5);

    repeat (3) @(posedge clk);
    chk("beat_queue_empty", 32'(beat_q.size()), 32'h0);
    chk("load_queue_empty", 32'(load_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
